// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers, one bit per cycle.
// Define MULT_DIV_SIGNED_EN to enable signed MULT/DIV; otherwise every operation is unsigned.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t               state_r, state_next_s;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     rs_r, rt_r, opb_r;
    logic [2*WIDTH-1:0]   acc_r, acc_step_s, prod_s;
    logic [CNT_W-1:0]     count_r;
    logic                 neg_res_r, neg_rem_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 busy_r, done_r, dbz_r;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s, quo_s, rem_s, fix_hi_s, fix_lo_s;
    logic                 neg_res_s, neg_rem_s, div_zero_s;
    logic [WIDTH:0]       sum_s, top_s, diff_s;

    assign div_zero_s = op_r[1] && (rt_r == {WIDTH{1'b0}});

`ifdef MULT_DIV_SIGNED_EN
    logic signed_s;

    // Operand magnitudes and result signs for the signed opcodes
    always_comb begin
        signed_s  = ~op_r[0];
        mag_a_s   = (signed_s && rs_r[WIDTH-1]) ? -rs_r : rs_r;
        mag_b_s   = (signed_s && rt_r[WIDTH-1]) ? -rt_r : rt_r;
        neg_res_s = signed_s && (rs_r[WIDTH-1] ^ rt_r[WIDTH-1]);
        neg_rem_s = signed_s && rs_r[WIDTH-1];
    end
`else
    logic unused_op_s;
    assign unused_op_s = op_r[0];

    // Unsigned-only build: operands pass straight through
    always_comb begin
        mag_a_s   = rs_r;
        mag_b_s   = rt_r;
        neg_res_s = 1'b0;
        neg_rem_s = 1'b0;
    end
`endif

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
        top_s  = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s = top_s - {1'b0, opb_r};
        if (op_r[1]) begin
            if (top_s >= {1'b0, opb_r}) begin
                acc_step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {top_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                acc_step_s = {sum_s, acc_r[WIDTH-1:1]};
            end else begin
                acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
            end
        end
    end

    // Sign correction applied when leaving FIX
    always_comb begin
        prod_s = neg_res_r ? -acc_r : acc_r;
        quo_s  = neg_res_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        rem_s  = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        if (op_r[1]) begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end else begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = PREP;
                else       state_next_s = IDLE;
            end
            PREP: begin
                if (div_zero_s) state_next_s = DONE;
                else            state_next_s = CALC;
            end
            CALC: begin
                if (count_r == {CNT_W{1'b0}}) state_next_s = FIX;
                else                          state_next_s = CALC;
            end
            FIX:  state_next_s = DONE;
            DONE: begin
                if (start) state_next_s = PREP;
                else       state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == PREP) || (state_next_s == CALC) || (state_next_s == FIX);
            done_r  <= (state_next_s == DONE);
            dbz_r   <= (state_r == PREP) && div_zero_s;
        end
    end

    // Operand capture, iteration datapath and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r      <= 2'b00;
            rs_r      <= {WIDTH{1'b0}};
            rt_r      <= {WIDTH{1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            count_r   <= {CNT_W{1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        op_r <= op;
                        rs_r <= rs_data;
                        rt_r <= rt_data;
                    end
                end
                PREP: begin
                    acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
                    opb_r     <= mag_b_s;
                    count_r   <= CNT_W'(WIDTH - 1);
                    neg_res_r <= neg_res_s;
                    neg_rem_r <= neg_rem_s;
                    if (div_zero_s) begin
                        hi_r <= rs_r;
                        lo_r <= {WIDTH{1'b1}};
                    end
                end
                CALC: begin
                    acc_r   <= acc_step_s;
                    count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    hi_r <= fix_hi_s;
                    lo_r <= fix_lo_s;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
